// File: rtl/guia_pkg.sv
// Shared definitions for truth_table_checker.
// Holds the FSM state encoding as localparams so that benches can probe the
// state directly, plus the width of the settle down-counter.
package guia_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        WAIT  = ST_WAIT,
        CHECK = ST_CHECK,
        DONE  = ST_DONE
    } state_t;

    // SETTLE is limited to 0..15.
    localparam int SETTLE_W = 4;

endpackage

// File: rtl/truth_table_checker_sweep_counter.sv
// sweep_counter: input-vector register and settle down-counter.
// Ports:
//   clk, reset     clock, async active-high reset
//   clear          vec <= 0, counter <= SETTLE (start of sweep)
//   step           vec <= vec+1, counter <= SETTLE (next vector)
//   dec            counter <= counter-1 (settling)
//   vec            current input vector
//   cnt_zero       settle counter has reached zero
//   all_ones       vec is the last vector of the sweep
module sweep_counter
    import guia_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int SETTLE = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            step,
    input  logic            dec,
    output logic [N_IN-1:0] vec,
    output logic            cnt_zero,
    output logic            all_ones
);

    localparam logic [SETTLE_W-1:0] SETTLE_V = SETTLE_W'(SETTLE);

    logic [SETTLE_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vec <= '0;
            cnt <= '0;
        end else if (clear) begin
            vec <= '0;
            cnt <= SETTLE_V;
        end else if (step) begin
            vec <= vec + N_IN'(1);
            cnt <= SETTLE_V;
        end else if (dec) begin
            cnt <= cnt - SETTLE_W'(1);
        end
    end

    assign cnt_zero = (cnt == '0);
    assign all_ones = &vec;

endmodule

// File: rtl/truth_table_checker.sv
// truth_table_checker: sweeps every N_IN-bit input vector into a pair of
// combinational function modules and compares their outputs bit-for-bit.
// Ports:
//   clk, reset        clock, async active-high reset
//   start             one-cycle sweep request (ignored while busy)
//   vec               vector driven to both function modules
//   ref_out, dut_out  outputs of the original / simplified expression
//   busy, done, pass  sweep status; pass only meaningful with done
//   fail_count        number of mismatching vectors (holds up to 2^N_IN)
//   err_mask          sticky OR of per-bit mismatches
//   first_fail_vec    first mismatching vector, valid with first_fail_valid
module truth_table_checker
    import guia_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int N_OUT  = 2,
    parameter int SETTLE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [N_IN-1:0]  vec,
    input  logic [N_OUT-1:0] ref_out,
    input  logic [N_OUT-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N_IN:0]    fail_count,
    output logic [N_OUT-1:0] err_mask,
    output logic [N_IN-1:0]  first_fail_vec,
    output logic             first_fail_valid
);

    state_t state, state_nxt;
    logic   clear, step, dec;
    logic   cnt_zero, all_ones;
    logic [N_OUT-1:0] mism;

    sweep_counter #(.N_IN(N_IN), .SETTLE(SETTLE)) u_sweep (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .step     (step),
        .dec      (dec),
        .vec      (vec),
        .cnt_zero (cnt_zero),
        .all_ones (all_ones)
    );

    // Case inequality so that X/Z on either side is reported as a mismatch.
    always_comb begin
        mism = '0;
        for (int i = 0; i < N_OUT; i++)
            mism[i] = (ref_out[i] !== dut_out[i]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        step      = 1'b0;
        dec       = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    clear     = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cnt_zero) state_nxt = CHECK;
                else          dec       = 1'b1;
            end
            CHECK: begin
                // vec holds at all-ones after the last check; never wraps.
                if (all_ones) begin
                    state_nxt = DONE;
                end else begin
                    step      = 1'b1;
                    state_nxt = WAIT;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fail_count       <= '0;
            err_mask         <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else if (clear) begin
            fail_count       <= '0;
            err_mask         <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else if (state == CHECK && |mism) begin
            fail_count <= fail_count + (N_IN+1)'(1);
            err_mask   <= err_mask | mism;
            if (!first_fail_valid) begin
                first_fail_vec   <= vec;
                first_fail_valid <= 1'b1;
            end
        end
    end

    assign busy = (state == WAIT) || (state == CHECK);
    assign done = (state == DONE);
    assign pass = done && (fail_count == '0);

endmodule

// File: tb/tb_truth_table_checker.sv
module tb_truth_table_checker;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start0 = 1'b0, start3 = 1'b0;
    int   mode = 0;

    logic [1:0] vec0, vec3, ref0, ref3, dout0, dout3, mask0, mask3, ffv0, ffv3;
    logic [2:0] fc0, fc3;
    logic busy0, busy3, done0, done3, pass0, pass3, ffval0, ffval3;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [2:0] fc;
        logic [1:0] mask;
        logic [1:0] ffv;
        logic       ffval;
        logic       pass;
        int         cycles;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    // Original expression: {~x&~(x|~y), (x|~y)|(x&y)}
    function automatic logic [1:0] f_ref(input logic [1:0] v);
        logic x, y;
        x = v[1]; y = v[0];
        return {~x & ~(x | ~y), (x | ~y) | (x & y)};
    endfunction

    // mode 0: correct simplification, 1: bit1 = y, 2: bit0 stuck at X
    function automatic logic [1:0] f_dut(input logic [1:0] v, input int m);
        logic x, y;
        x = v[1]; y = v[0];
        case (m)
            1:       return {y, ~y | x};
            2:       return {~x & y, 1'bx};
            default: return {~x & y, ~y | x};
        endcase
    endfunction

    assign ref0  = f_ref(vec0);
    assign dout0 = f_dut(vec0, mode);
    assign ref3  = f_ref(vec3);
    assign dout3 = f_dut(vec3, mode);

    truth_table_checker #(.N_IN(2), .N_OUT(2), .SETTLE(0)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .vec(vec0),
        .ref_out(ref0), .dut_out(dout0), .busy(busy0), .done(done0),
        .pass(pass0), .fail_count(fc0), .err_mask(mask0),
        .first_fail_vec(ffv0), .first_fail_valid(ffval0)
    );

    truth_table_checker #(.N_IN(2), .N_OUT(2), .SETTLE(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .vec(vec3),
        .ref_out(ref3), .dut_out(dout3), .busy(busy3), .done(done3),
        .pass(pass3), .fail_count(fc3), .err_mask(mask3),
        .first_fail_vec(ffv3), .first_fail_valid(ffval3)
    );

    // Reference sweep model: push the expected verdict for one sweep.
    task automatic push_expected(input int m, input int settle);
        exp_t e;
        logic [1:0] v, mm, r, d;
        e.fc = 0; e.mask = 0; e.ffv = 0; e.ffval = 0;
        for (int i = 0; i < 4; i++) begin
            v = 2'(i);
            r = f_ref(v);
            d = f_dut(v, m);
            mm = {r[1] !== d[1], r[0] !== d[0]};
            if (mm != 2'b00) begin
                e.fc++;
                e.mask |= mm;
                if (!e.ffval) begin e.ffv = v; e.ffval = 1'b1; end
            end
        end
        e.pass   = (e.fc == 0);
        e.cycles = 4 * (settle + 2);
        sb.push_back(e);
    endtask

    // Pulse start on the selected DUT, count busy cycles, then check verdict.
    task automatic run_sweep(input bit sel3, input int settle, input bit poke,
                             input bit trace, input bit chk_clr, input string nm);
        int cycles;
        exp_t e;
        logic b;
        @(negedge clk);
        if (sel3) start3 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; start3 = 1'b0;
        cycles = 0;
        b = sel3 ? busy3 : busy0;
        if (chk_clr) begin
            n_tests++;
            if ({fc0, ffval0, mask0} !== 6'b0) begin
                n_fail++;
                $display("FAIL %s_clear: fc=%0d ffval=%b mask=%b, want 0", nm, fc0, ffval0, mask0);
            end
        end
        while (b && cycles < 200) begin
            if (trace) begin
                n_tests++;
                if (vec3 !== 2'(cycles / (settle + 2))) begin
                    n_fail++;
                    $display("FAIL %s_vec cyc%0d: got %b want %b", nm, cycles, vec3, 2'(cycles / (settle + 2)));
                end
            end
            cycles++;
            if (poke && cycles == 3) begin
                if (sel3) start3 = 1'b1; else start0 = 1'b1;
            end else begin
                start0 = 1'b0; start3 = 1'b0;
            end
            @(negedge clk);
            b = sel3 ? busy3 : busy0;
        end
        start0 = 1'b0; start3 = 1'b0;
        e = sb.pop_front();
        n_tests++;
        if (cycles >= 200) begin
            n_fail++;
            $display("FAIL %s_timeout: busy never dropped", nm);
            return;
        end
        if (cycles != e.cycles) begin
            n_fail++;
            $display("FAIL %s_cycles: got %0d want %0d", nm, cycles, e.cycles);
        end
        n_tests++;
        if ((sel3 ? done3 : done0) !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_done: got %b want 1", nm, sel3 ? done3 : done0);
        end
        n_tests++;
        if ((sel3 ? fc3 : fc0) !== e.fc) begin
            n_fail++;
            $display("FAIL %s_fail_count: got %0d want %0d", nm, sel3 ? fc3 : fc0, e.fc);
        end
        n_tests++;
        if ((sel3 ? mask3 : mask0) !== e.mask) begin
            n_fail++;
            $display("FAIL %s_err_mask: got %b want %b", nm, sel3 ? mask3 : mask0, e.mask);
        end
        n_tests++;
        if ((sel3 ? pass3 : pass0) !== e.pass) begin
            n_fail++;
            $display("FAIL %s_pass: got %b want %b", nm, sel3 ? pass3 : pass0, e.pass);
        end
        n_tests++;
        if ((sel3 ? ffval3 : ffval0) !== e.ffval) begin
            n_fail++;
            $display("FAIL %s_ffvalid: got %b want %b", nm, sel3 ? ffval3 : ffval0, e.ffval);
        end
        if (e.ffval) begin
            n_tests++;
            if ((sel3 ? ffv3 : ffv0) !== e.ffv) begin
                n_fail++;
                $display("FAIL %s_ffvec: got %b want %b", nm, sel3 ? ffv3 : ffv0, e.ffv);
            end
        end
        // Outputs hold in DONE.
        @(negedge clk);
        n_tests++;
        if ((sel3 ? {done3, fc3} : {done0, fc0}) !== {1'b1, e.fc}) begin
            n_fail++;
            $display("FAIL %s_hold: got done/fc %b want %b", nm,
                     sel3 ? {done3, fc3} : {done0, fc0}, {1'b1, e.fc});
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        n_tests++;
        if ({vec0, busy0, done0, pass0, fc0, mask0, ffv0, ffval0} !== 13'b0) begin
            n_fail++;
            $display("FAIL reset_dut0: got %b want 0", {vec0, busy0, done0, pass0, fc0, mask0, ffv0, ffval0});
        end
        n_tests++;
        if ({vec3, busy3, done3, pass3, fc3, mask3, ffv3, ffval3} !== 13'b0) begin
            n_fail++;
            $display("FAIL reset_dut3: got %b want 0", {vec3, busy3, done3, pass3, fc3, mask3, ffv3, ffval3});
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_equiv();
        mode = 0; push_expected(0, 0);
        run_sweep(1'b0, 0, 1'b0, 1'b0, 1'b0, "equiv");
    endtask

    task automatic test_bad_simpl();
        mode = 1; push_expected(1, 0);
        run_sweep(1'b0, 0, 1'b0, 1'b0, 1'b1, "bad");
    endtask

    task automatic test_xprop();
        mode = 2; push_expected(2, 0);
        run_sweep(1'b0, 0, 1'b0, 1'b0, 1'b1, "xprop");
    endtask

    task automatic test_settle();
        mode = 0; push_expected(0, 3);
        run_sweep(1'b1, 3, 1'b0, 1'b1, 1'b0, "settle3");
    endtask

    task automatic test_start_busy();
        mode = 0; push_expected(0, 0);
        run_sweep(1'b0, 0, 1'b1, 1'b0, 1'b0, "busy_start");
    endtask

    task automatic test_restart();
        mode = 1; push_expected(1, 0);
        run_sweep(1'b0, 0, 1'b0, 1'b0, 1'b0, "restart_a");
        mode = 0; push_expected(0, 0);
        run_sweep(1'b0, 0, 1'b0, 1'b0, 1'b1, "restart_b");
    endtask

    task automatic test_mid_reset();
        int n;
        mode = 1;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        n = 0;
        while (vec0 !== 2'b10 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (vec0 !== 2'b10) begin
            n_fail++;
            $display("FAIL midreset_reach: vec got %b want 10", vec0);
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if ({vec0, busy0, done0, pass0, fc0, mask0, ffv0, ffval0} !== 13'b0) begin
            n_fail++;
            $display("FAIL midreset_clear: got %b want 0", {vec0, busy0, done0, pass0, fc0, mask0, ffv0, ffval0});
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({busy0, done0, vec0} !== 4'b0) begin
            n_fail++;
            $display("FAIL midreset_idle: busy/done/vec got %b want 0000", {busy0, done0, vec0});
        end
    endtask

    initial begin
        test_reset();
        test_equiv();
        test_bad_simpl();
        test_xprop();
        test_settle();
        test_start_busy();
        test_restart();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
